// File: rtl/prbs_pkg.sv
// Shared PRBS31 definitions: polynomial taps, checker state encoding and default parameters.
package prbs_pkg;

  localparam int unsigned PRBS31_LEN   = 31;
  localparam int unsigned PRBS31_TAP_A = 27;
  localparam int unsigned PRBS31_TAP_B = 30;

  localparam int unsigned DEF_LOCK_MATCHES = 64;
  localparam int unsigned DEF_LOSS_ERRORS  = 8;
  localparam int unsigned DEF_LOSS_WINDOW  = 256;
  localparam int unsigned DEF_ERR_W        = 16;

  // 2'd3 is unused and recovers to ST_SEED
  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2
  } prbs_state_e;

  // Next bit of the x^31 + x^28 + 1 sequence given the last 31 bits (newest in bit 0)
  function automatic logic prbs31_fb(input logic [PRBS31_LEN-1:0] s);
    return s[PRBS31_TAP_A] ^ s[PRBS31_TAP_B];
  endfunction

endpackage

// File: rtl/prbs31_predictor.sv
// 31-bit history register of the PRBS31 checker: predicts the next bit and
// shifts in either the received bit (acquisition) or its own prediction (free-run).
module prbs31_predictor
  import prbs_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic shift_en_i,
  input  logic load_exp_i,
  input  logic rx_bit_i,
  output logic exp_o,
  output logic all_zero_o
);

  logic [PRBS31_LEN-1:0] s_q;
  logic [PRBS31_LEN-1:0] s_d;
  logic                  exp_c;

  always_comb begin
    exp_c = prbs31_fb(s_q);
    s_d   = s_q;
    if (shift_en_i) begin
      s_d = {s_q[PRBS31_LEN-2:0], (load_exp_i ? exp_c : rx_bit_i)};
    end
  end

  // rst_n is active-high despite its name
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

  assign exp_o      = exp_c;
  assign all_zero_o = (s_q == '0);

endmodule

// File: rtl/prbs31_checker.sv
// Serial PRBS31 checker: self-synchronises to the incoming stream, declares lock,
// then counts bit errors and drops lock when too many errors land in one window.
module prbs31_checker
  import prbs_pkg::*;
#(
  parameter int unsigned LOCK_MATCHES = DEF_LOCK_MATCHES,
  parameter int unsigned LOSS_ERRORS  = DEF_LOSS_ERRORS,
  parameter int unsigned LOSS_WINDOW  = DEF_LOSS_WINDOW,
  parameter int unsigned ERR_W        = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_bit,
  input  logic             rx_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       state
);

  localparam int unsigned SEED_W  = $clog2(PRBS31_LEN);
  localparam int unsigned MATCH_W = $clog2(LOCK_MATCHES + 1);
  localparam int unsigned WIN_W   = $clog2(LOSS_WINDOW);
  localparam int unsigned WERR_W  = $clog2(LOSS_ERRORS + 1);

  prbs_state_e        state_q;
  logic [SEED_W-1:0]  seed_cnt_q;
  logic [MATCH_W-1:0] match_cnt_q;
  logic [WIN_W-1:0]   win_bits_q;
  logic [WERR_W-1:0]  win_err_q;
  logic [ERR_W-1:0]   err_count_q;
  logic [ERR_W-1:0]   err_count_d;
  logic               err_pulse_q;
  logic               locked_q;

  logic exp_bit;
  logic s_zero;
  logic shift_en_c;
  logic mismatch_c;
  logic lock_err_c;
  logic loss_c;
  logic win_wrap_c;

  prbs31_predictor u_pred (
    .clk        (clk),
    .rst_n      (rst_n),
    .shift_en_i (shift_en_c),
    .load_exp_i (state_q == ST_LOCKED),
    .rx_bit_i   (rx_bit),
    .exp_o      (exp_bit),
    .all_zero_o (s_zero)
  );

  always_comb begin
    shift_en_c = rx_valid && (state_q inside {ST_SEED, ST_HUNT, ST_LOCKED});
    mismatch_c = rx_bit ^ exp_bit;
    lock_err_c = rx_valid && (state_q == ST_LOCKED) && mismatch_c;
    loss_c     = lock_err_c && (win_err_q == WERR_W'(LOSS_ERRORS - 1));
    win_wrap_c = (win_bits_q == WIN_W'(LOSS_WINDOW - 1));
  end

  // Clear wins over a same-cycle error; the count sticks at all-ones
  always_comb begin
    err_count_d = err_count_q;
    if (clr_cnt) begin
      err_count_d = '0;
    end else if (lock_err_c && (err_count_q != '1)) begin
      err_count_d = err_count_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= ST_SEED;
      seed_cnt_q  <= '0;
      match_cnt_q <= '0;
      win_bits_q  <= '0;
      win_err_q   <= '0;
      err_count_q <= '0;
      err_pulse_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      err_count_q <= err_count_d;
      err_pulse_q <= lock_err_c;
      if (rx_valid) begin
        case (state_q)
          ST_SEED: begin
            if (seed_cnt_q == SEED_W'(PRBS31_LEN - 1)) begin
              state_q     <= ST_HUNT;
              seed_cnt_q  <= '0;
              match_cnt_q <= '0;
            end else begin
              seed_cnt_q <= seed_cnt_q + SEED_W'(1);
            end
          end
          ST_HUNT: begin
            // An all-zero history predicts zeros forever, so it never earns matches
            if (mismatch_c || s_zero) begin
              match_cnt_q <= '0;
            end else if (match_cnt_q == MATCH_W'(LOCK_MATCHES - 1)) begin
              state_q     <= ST_LOCKED;
              locked_q    <= 1'b1;
              match_cnt_q <= '0;
              win_bits_q  <= '0;
              win_err_q   <= '0;
            end else begin
              match_cnt_q <= match_cnt_q + MATCH_W'(1);
            end
          end
          ST_LOCKED: begin
            if (loss_c) begin
              state_q     <= ST_SEED;
              locked_q    <= 1'b0;
              seed_cnt_q  <= '0;
              match_cnt_q <= '0;
              win_bits_q  <= '0;
              win_err_q   <= '0;
            end else begin
              win_bits_q <= win_bits_q + WIN_W'(1);
              if (win_wrap_c) begin
                win_err_q <= '0;
              end else if (mismatch_c) begin
                win_err_q <= win_err_q + WERR_W'(1);
              end
            end
          end
          default: begin
            state_q     <= ST_SEED;
            locked_q    <= 1'b0;
            seed_cnt_q  <= '0;
            match_cnt_q <= '0;
            win_bits_q  <= '0;
            win_err_q   <= '0;
          end
        endcase
      end
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign state     = state_q;

endmodule

// File: tb/tb_prbs31_checker.sv
// Directed bench for prbs31_checker: scenario table of injected-error patterns plus
// hand sequences for reset, stuck-at-0 input, rx_valid gaps and clear/error collision.
module tb_prbs31_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rx_bit = 1'b0;
  logic        rx_valid = 1'b0;
  logic        clr_cnt = 1'b0;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [1:0]  state;

  int n_cmp  = 0;
  int n_fail = 0;
  int pulses = 0;
  logic [30:0] gen_q;

  prbs31_checker dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_bit    (rx_bit),
    .rx_valid  (rx_valid),
    .clr_cnt   (clr_cnt),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .state     (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n_a;
    int n_b;
    bit clr_first;
    int post_len;
    int exp_loss;
    int exp_relock;
    int exp_locked;
    int exp_cnt;
    int exp_pulses;
  } scn_t;

  scn_t scn[5];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference generator, seed 1, output is lfsr[30]
  task automatic gen_bit(output logic b);
    b = gen_q[30];
    gen_q = {gen_q[29:0], gen_q[27] ^ gen_q[30]};
  endtask

  task automatic send(input logic b, input logic v, input logic c);
    rx_bit   = b;
    rx_valid = v;
    clr_cnt  = c;
    @(posedge clk);
    #1;
    if (err_pulse) pulses++;
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rx_bit   = 1'b0;
    clr_cnt  = 1'b0;
    rst_n    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b0;
    gen_q  = 31'd1;
    pulses = 0;
  endtask

  task automatic lock_up(output int at);
    logic b;
    at = -1;
    for (int k = 1; k <= 300; k++) begin
      gen_bit(b);
      send(b, 1'b1, 1'b0);
      if (locked) begin
        at = k;
        break;
      end
    end
  endtask

  task automatic run_scn(input int idx, input scn_t r);
    int   lock_at, loss_at, relock_at;
    logic b, flip, clr;
    do_reset();
    lock_up(lock_at);
    check($sformatf("scn%0d_lock_bit", idx), lock_at, 95);
    pulses    = 0;
    loss_at   = -1;
    relock_at = -1;
    for (int j = 0; j < r.post_len; j++) begin
      gen_bit(b);
      flip = 1'b0;
      if (j < 256 && (j % 20) == 5 && (j / 20) < r.n_a) flip = 1'b1;
      if (j >= 256 && j < 512 && ((j - 256) % 20) == 5 && ((j - 256) / 20) < r.n_b) flip = 1'b1;
      clr = r.clr_first && (j == 5);
      send(b ^ flip, 1'b1, clr);
      if (clr) begin
        check($sformatf("scn%0d_clr_same_cycle_cnt", idx), int'(err_count), 0);
        check($sformatf("scn%0d_clr_same_cycle_pulse", idx), int'(err_pulse), 1);
      end
      if (loss_at < 0 && !locked) loss_at = j;
      else if (loss_at >= 0 && relock_at < 0 && locked) relock_at = j;
    end
    check($sformatf("scn%0d_loss_bit", idx), loss_at, r.exp_loss);
    check($sformatf("scn%0d_relock_bit", idx), relock_at, r.exp_relock);
    check($sformatf("scn%0d_locked", idx), int'(locked), r.exp_locked);
    check($sformatf("scn%0d_err_count", idx), int'(err_count), r.exp_cnt);
    check($sformatf("scn%0d_pulses", idx), pulses, r.exp_pulses);
  endtask

  initial begin
    int   at, vb, saw_locked;
    logic b;

    //            n_a n_b clr  len    loss relock lk cnt pulses
    scn[0] = '{0,  0,  1'b0, 10000, -1,  -1,    1, 0,  0};
    scn[1] = '{1,  0,  1'b0, 700,   -1,  -1,    1, 1,  1};
    scn[2] = '{7,  7,  1'b0, 700,   -1,  -1,    1, 14, 14};
    scn[3] = '{8,  0,  1'b0, 700,   145, 240,   1, 8,  8};
    scn[4] = '{3,  0,  1'b1, 700,   -1,  -1,    1, 2,  3};

    // Reset values while reset is held
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_locked", int'(locked), 0);
    check("rst_err_pulse", int'(err_pulse), 0);
    check("rst_err_count", int'(err_count), 0);
    check("rst_state", int'(state), 0);

    for (int i = 0; i < 5; i++) run_scn(i, scn[i]);

    // Stuck-at-0 input never locks
    do_reset();
    saw_locked = 0;
    for (int k = 0; k < 1000; k++) begin
      send(1'b0, 1'b1, 1'b0);
      if (state == 2'd2 || locked) saw_locked = 1;
    end
    check("stuck0_never_locked", saw_locked, 0);
    check("stuck0_state_hunt", int'(state), 1);
    check("stuck0_err_count", int'(err_count), 0);

    // rx_valid toggling: lock on the 95th valid bit, cycle 189
    do_reset();
    vb = 0;
    at = -1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      if (cyc % 2 == 1) begin
        gen_bit(b);
        send(b, 1'b1, 1'b0);
        vb++;
      end else begin
        send(1'($urandom), 1'b0, 1'b0);
      end
      if (locked) begin
        at = cyc;
        break;
      end
    end
    check("toggle_lock_valid_bits", vb, 95);
    check("toggle_lock_cycle", at, 189);

    // Invalid cycles while locked are transparent even with junk data
    pulses = 0;
    for (int k = 0; k < 20; k++) send(1'($urandom), 1'b0, 1'b0);
    check("gap_pulses", pulses, 0);
    check("gap_err_count", int'(err_count), 0);
    for (int k = 0; k < 100; k++) begin
      gen_bit(b);
      send(b, 1'b1, 1'b0);
    end
    check("gap_still_locked", int'(locked), 1);
    check("gap_no_errors", int'(err_count), 0);

    // Asynchronous reset while locked, mid-cycle
    gen_bit(b);
    send(~b, 1'b1, 1'b0);
    check("prerst_err_pulse", int'(err_pulse), 1);
    check("prerst_err_count", int'(err_count), 1);
    #2;
    rst_n = 1'b1;
    #1;
    check("midrst_locked", int'(locked), 0);
    check("midrst_err_pulse", int'(err_pulse), 0);
    check("midrst_err_count", int'(err_count), 0);
    check("midrst_state", int'(state), 0);
    do_reset();
    lock_up(at);
    check("postrst_lock_bit", at, 95);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
